reset_sequencer: RTL



---
 rtl/reset_sequencer_pkg.sv | 8 +
 rtl/rst_sync2.sv | 11 +
 rtl/reset_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encodings and reset-cause codes shared by the reset sequencer
package reset_sequencer_pkg;
    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_STAGE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic CAUSE_EXT = 1'b0;
    localparam logic CAUSE_SW  = 1'b1;
endpackage

// File: rtl/rst_sync2.sv
// rst_sync2: two-flop reset-release synchroniser with asynchronous clear
module rst_sync2 (
    input  logic clk,
    input  logic rst_in_n,
    output logic s2
);
    logic s1;
    always_ff @(posedge clk or negedge rst_in_n)
        if (!rst_in_n) {s2, s1} <= 2'b00;
        else {s2, s1} <= {s1, 1'b1};
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered multi-domain reset release with software re-sequence request
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_OUT   = 1,
    parameter int CNT_SIZE  = 4,
    parameter int STAGE_GAP = 1
) (
    input  logic               clk,
    input  logic               rst_in_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done,
    output logic               last_cause
);
`ifdef SIMULATE
    initial begin
        if (NUM_OUT < 1 || NUM_OUT > 8) $error("NUM_OUT out of range 1..8");
        if (CNT_SIZE < 2 || CNT_SIZE > 20) $error("CNT_SIZE out of range 2..20");
        if (STAGE_GAP < 1 || STAGE_GAP > 255) $error("STAGE_GAP out of range 1..255");
    end
`endif
    logic                s2;
    logic [1:0]          state;
    logic [CNT_SIZE:0]   cnt;
    logic [7:0]          gap;
    logic [2:0]          stage_idx;
    logic [NUM_OUT-1:0]  next_bit;
    logic                last_stage;
    logic                gap_hit;
    rst_sync2 u_sync (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .s2       (s2)
    );
    assign next_bit   = NUM_OUT'(1) << stage_idx;
    assign last_stage = stage_idx == 3'(NUM_OUT - 1);
    assign gap_hit    = gap == 8'(STAGE_GAP - 1);
    always_ff @(posedge clk or negedge rst_in_n)
        if (!rst_in_n) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            gap        <= '0;
            stage_idx  <= '0;
            rst_out_n  <= '0;
            rst_done   <= 1'b0;
            last_cause <= CAUSE_EXT;
        end else if (soft_rst_req) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            gap        <= '0;
            stage_idx  <= '0;
            rst_out_n  <= '0;
            rst_done   <= 1'b0;
            last_cause <= CAUSE_SW;
        end else begin
            case (state)
                ST_HOLD:
                    if (cnt[CNT_SIZE]) begin
                        rst_out_n <= rst_out_n | NUM_OUT'(1);
                        gap       <= '0;
                        stage_idx <= 3'd1;
                        state     <= NUM_OUT == 1 ? ST_DONE : ST_STAGE;
                        rst_done  <= NUM_OUT == 1;
                    end else if (s2) begin
                        cnt <= cnt + 1'b1;
                    end
                ST_STAGE:
                    if (gap_hit) begin
                        rst_out_n <= rst_out_n | next_bit;
                        gap       <= '0;
                        stage_idx <= stage_idx + 3'd1;
                        state     <= last_stage ? ST_DONE : ST_STAGE;
                        rst_done  <= last_stage;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                ST_DONE: ;
                default: state <= ST_HOLD;
            endcase
        end
endmodule
